// File: rtl/ift_mmio_ctrl_if.sv
// MMIO bus between the core (master) and ift_mmio_ctrl (slave).
// Every signal has a matching _t0 taint shadow.
interface ift_mmio_ctrl_if #(
  parameter int unsigned AddrWidth = 32
);
  logic                 mmio_req_i;
  logic [AddrWidth-1:0] mmio_addr_i;
  logic [63:0]          mmio_wdata_i;
  logic [7:0]           mmio_strb_i;
  logic                 mmio_we_i;
  logic [63:0]          mmio_rdata_o;

  logic                 mmio_req_i_t0;
  logic [AddrWidth-1:0] mmio_addr_i_t0;
  logic [63:0]          mmio_wdata_i_t0;
  logic [7:0]           mmio_strb_i_t0;
  logic                 mmio_we_i_t0;
  logic [63:0]          mmio_rdata_o_t0;

  modport master (
    output mmio_req_i, mmio_addr_i, mmio_wdata_i, mmio_strb_i, mmio_we_i,
    output mmio_req_i_t0, mmio_addr_i_t0, mmio_wdata_i_t0, mmio_strb_i_t0, mmio_we_i_t0,
    input  mmio_rdata_o, mmio_rdata_o_t0
  );

  modport slave (
    input  mmio_req_i, mmio_addr_i, mmio_wdata_i, mmio_strb_i, mmio_we_i,
    input  mmio_req_i_t0, mmio_addr_i_t0, mmio_wdata_i_t0, mmio_strb_i_t0, mmio_we_i_t0,
    output mmio_rdata_o, mmio_rdata_o_t0
  );
endinterface

// File: rtl/ift_mmio_ctrl.sv
// Taint-tracked MMIO target with STOP / PUTC / CYCLE / STATUS registers and a console FIFO.
// Define MMIO_TAINT_TRAP_EN to replace tainted STOP codes with a fixed trap code.
module ift_mmio_ctrl #(
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 64,
  parameter logic [AddrWidth-1:0] BaseAddr    = AddrWidth'(32'h1000_0000),
  parameter int unsigned          FifoDepth   = 8,
  parameter int unsigned          DrainCycles = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  ift_mmio_ctrl_if.slave mmio,
  output logic           cons_valid_o,
  output logic [7:0]     cons_data_o,
  output logic [7:0]     cons_data_o_t0,
  input  logic           cons_ready_i,
  output logic           stop_o,
  output logic [63:0]    stop_code_o,
  output logic [63:0]    stop_code_o_t0,
  output logic           taint_alarm_o
);

  if (DataWidth != 64) begin : g_bad_data_width
    $error("ift_mmio_ctrl: DataWidth must be 64");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_fifo_depth
    $error("ift_mmio_ctrl: FifoDepth must be a power of two and at least 2");
  end
  if (AddrWidth < 6) begin : g_bad_addr_width
    $error("ift_mmio_ctrl: AddrWidth too small for the register window");
  end

  localparam int unsigned PtrW   = $clog2(FifoDepth);
  localparam int unsigned CntW   = $clog2(FifoDepth + 1);
  localparam int unsigned DrainW = $clog2(DrainCycles + 2);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StDrain   = 2'd1,
    StStopped = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0] off;
  logic                 hit;
  logic [1:0]           sel;
  logic                 rd_req;
  logic                 wr_hit;
  logic                 ctrl_taint;
  logic                 stop_wr;
  logic                 putc_wr;
  logic                 stat_wr;
  logic                 trap;
  logic [63:0]          mask;

  logic [7:0]           fifo_data  [FifoDepth];
  logic [7:0]           fifo_taint [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 full, empty, pop, push;

  logic                 ovf_q;
  logic                 alarm_q;
  logic [63:0]          cycle_q;
  logic [63:0]          stop_code_q, stop_t0_q;
  logic [DrainW-1:0]    drain_q;
  logic [63:0]          rdata_q, rdata_t0_q;
  logic [63:0]          rd_val, rd_t0;
  logic [63:0]          status;
  logic                 unused_off_bits;

  // The window is 32 bytes, so a hit means every offset bit above bit 4 is zero;
  // addresses below BaseAddr wrap to a huge offset and miss naturally.
  assign off             = mmio.mmio_addr_i - BaseAddr;
  assign hit             = (off[AddrWidth-1:5] == '0);
  assign sel             = off[4:3];
  assign unused_off_bits = ^off[2:0];

  assign rd_req     = mmio.mmio_req_i && !mmio.mmio_we_i;
  assign wr_hit     = mmio.mmio_req_i && mmio.mmio_we_i && hit;
  assign ctrl_taint = mmio.mmio_req_i &&
                      ((|mmio.mmio_addr_i_t0) || mmio.mmio_we_i_t0 ||
                       mmio.mmio_req_i_t0 || (|mmio.mmio_strb_i_t0));

  assign stop_wr = wr_hit && (sel == 2'd0) && (state_q == StRun);
  assign putc_wr = wr_hit && (sel == 2'd1) && mmio.mmio_strb_i[0];
  assign stat_wr = wr_hit && (sel == 2'd3);

  always_comb begin
    mask = '0;
    for (int b = 0; b < 8; b++) begin
      mask[b*8 +: 8] = {8{mmio.mmio_strb_i[b]}};
    end
  end

`ifdef MMIO_TAINT_TRAP_EN
  assign trap = stop_wr && ((mmio.mmio_wdata_i_t0 & mask) != '0);
`else
  assign trap = 1'b0;
`endif

  // A push into a full FIFO still succeeds if the head leaves in the same cycle.
  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(FifoDepth));
  assign pop   = !empty && cons_ready_i;
  assign push  = putc_wr && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr_q]  <= mmio.mmio_wdata_i[7:0];
      fifo_taint[wr_ptr_q] <= mmio.mmio_wdata_i_t0[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:     if (stop_wr) state_d = StDrain;
      StDrain:   if (drain_q == '0 && empty) state_d = StStopped;
      StStopped: state_d = StStopped;
      default:   state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      alarm_q     <= 1'b0;
      cycle_q     <= '0;
      stop_code_q <= '0;
      stop_t0_q   <= '0;
      drain_q     <= '0;
      rdata_q     <= '0;
      rdata_t0_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);

      if (putc_wr && full && !pop) begin
        ovf_q <= 1'b1;
      end else if (stat_wr && mmio.mmio_wdata_i[8]) begin
        ovf_q <= 1'b0;
      end

      if (ctrl_taint || trap) alarm_q <= 1'b1;

      if (state_q != StStopped) cycle_q <= cycle_q + 64'd1;

      if (stop_wr) begin
        if (trap) begin
          stop_code_q <= 64'hDEAD_7A1E;
          stop_t0_q   <= '1;
        end else begin
          stop_code_q <= (stop_code_q & ~mask) | (mmio.mmio_wdata_i & mask);
          stop_t0_q   <= (stop_t0_q & ~mask) | (mmio.mmio_wdata_i_t0 & mask);
        end
        drain_q <= DrainW'(DrainCycles);
      end else if (state_q == StDrain && drain_q != '0) begin
        drain_q <= drain_q - DrainW'(1);
      end

      if (rd_req) begin
        rdata_q    <= rd_val;
        rdata_t0_q <= rd_t0;
      end
    end
  end

  assign status = {52'd0, state_q, alarm_q, ovf_q, 8'(count_q)};

  // A tainted address/strobe/enable makes the whole response untrusted.
  always_comb begin
    rd_val = '0;
    rd_t0  = '0;
    if (hit) begin
      unique case (sel)
        2'd0: begin
          rd_val = stop_code_q;
          rd_t0  = stop_t0_q;
        end
        2'd2:    rd_val = cycle_q;
        2'd3:    rd_val = status;
        default: rd_val = '0;
      endcase
    end
    if (ctrl_taint) rd_t0 = '1;
  end

  assign mmio.mmio_rdata_o    = rdata_q;
  assign mmio.mmio_rdata_o_t0 = rdata_t0_q;

  assign cons_valid_o   = !empty;
  assign cons_data_o    = empty ? 8'h00 : fifo_data[rd_ptr_q];
  assign cons_data_o_t0 = empty ? 8'h00 : fifo_taint[rd_ptr_q];

  assign stop_o         = (state_q == StStopped);
  assign stop_code_o    = stop_code_q;
  assign stop_code_o_t0 = stop_t0_q;
  assign taint_alarm_o  = alarm_q;

endmodule

// File: tb/tb_ift_mmio_ctrl.sv
// Scoreboard bench for ift_mmio_ctrl: random and directed MMIO traffic checked against a
// transaction-level model; define MMIO_TAINT_TRAP_EN to also exercise the trap path.
module tb_ift_mmio_ctrl;
  localparam longint unsigned BASE   = 64'h1000_0000;
  localparam logic [31:0]     BASE32 = 32'h1000_0000;
  localparam int              DEPTH  = 8;
  localparam int              DRAIN  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cons_valid;
  logic [7:0]  cons_data, cons_data_t0;
  logic        cons_ready = 1'b0;
  logic        stop;
  logic [63:0] stop_code, stop_code_t0;
  logic        taint_alarm;

  ift_mmio_ctrl_if #(.AddrWidth(32)) bus ();

  ift_mmio_ctrl #(
    .AddrWidth  (32),
    .DataWidth  (64),
    .BaseAddr   (BASE32),
    .FifoDepth  (DEPTH),
    .DrainCycles(DRAIN)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mmio          (bus),
    .cons_valid_o  (cons_valid),
    .cons_data_o   (cons_data),
    .cons_data_o_t0(cons_data_t0),
    .cons_ready_i  (cons_ready),
    .stop_o        (stop),
    .stop_code_o   (stop_code),
    .stop_code_o_t0(stop_code_t0),
    .taint_alarm_o (taint_alarm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] data;
    logic [63:0] taint;
  } rd_exp_t;

  rd_exp_t     exp_rd[$];
  logic [15:0] exp_cons[$];
  logic [15:0] cons_head;
  rd_exp_t     rd_head;

  // Reference model state: {taint, data} per console byte, state 0=RUN 1=DRAIN 2=STOPPED.
  longint unsigned m_cycle;
  int              m_state;
  int              m_age;
  logic [15:0]     m_fifo[$];
  bit              m_ovf;
  bit              m_alarm;
  logic [63:0]     m_stop, m_stop_t0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    m_cycle = 0; m_state = 0; m_age = 0;
    m_fifo.delete(); exp_cons.delete(); exp_rd.delete();
    m_ovf = 0; m_alarm = 0; m_stop = '0; m_stop_t0 = '0;
  endfunction

  function automatic void modelStep();
    longint unsigned a;
    bit          hit, tainted, pop, push_req;
    int          sel, pre_size, pre_state;
    logic [63:0] mask, rv, rt;
    a         = 64'(bus.mmio_addr_i);
    hit       = (a >= BASE) && (a < BASE + 32);
    sel       = int'((a - BASE) / 8);
    for (int b = 0; b < 8; b++) mask[b*8 +: 8] = bus.mmio_strb_i[b] ? 8'hFF : 8'h00;
    tainted   = bus.mmio_req_i && (bus.mmio_addr_i_t0 != 0 || bus.mmio_we_i_t0 ||
                                   bus.mmio_req_i_t0 || bus.mmio_strb_i_t0 != 0);
    pre_size  = m_fifo.size();
    pre_state = m_state;
    pop       = (pre_size > 0) && cons_ready;
    push_req  = 0;

    if (bus.mmio_req_i && !bus.mmio_we_i) begin
      rv = '0; rt = '0;
      if (hit) begin
        case (sel)
          0: begin rv = m_stop; rt = m_stop_t0; end
          2: rv = m_cycle;
          3: rv = 64'(pre_size) + (64'(m_ovf) << 8) + (64'(m_alarm) << 9) + (64'(m_state) << 10);
          default: ;
        endcase
      end
      if (tainted) rt = '1;
      exp_rd.push_back('{rv, rt});
    end

    if (bus.mmio_req_i && bus.mmio_we_i && hit) begin
      case (sel)
        0: if (pre_state == 0) begin
             m_state = 1;
             m_age   = 0;
`ifdef MMIO_TAINT_TRAP_EN
             if ((bus.mmio_wdata_i_t0 & mask) != 0) begin
               m_stop = 64'hDEAD_7A1E; m_stop_t0 = '1; m_alarm = 1;
             end else
`endif
             begin
               m_stop    = (m_stop & ~mask) | (bus.mmio_wdata_i & mask);
               m_stop_t0 = (m_stop_t0 & ~mask) | (bus.mmio_wdata_i_t0 & mask);
             end
           end
        1: push_req = bus.mmio_strb_i[0];
        3: if (bus.mmio_wdata_i[8]) m_ovf = 0;
        default: ;
      endcase
    end

    if (pop) void'(m_fifo.pop_front());
    if (push_req) begin
      if (pre_size < DEPTH || pop) begin
        m_fifo.push_back({bus.mmio_wdata_i_t0[7:0], bus.mmio_wdata_i[7:0]});
        exp_cons.push_back({bus.mmio_wdata_i_t0[7:0], bus.mmio_wdata_i[7:0]});
      end else begin
        m_ovf = 1;
      end
    end

    // DRAIN is left once at least DRAIN full cycles have passed and the FIFO was empty.
    if (pre_state == 1) begin
      if (m_age >= DRAIN && pre_size == 0) m_state = 2;
      else m_age++;
    end
    if (pre_state != 2) m_cycle++;
    if (tainted) m_alarm = 1;
  endfunction

  task automatic applyStimulus(input bit req, input bit we, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic [63:0] wdata_t0,
                               input logic [7:0] strb, input bit ctl_taint, input bit ready);
    @(negedge clk);
    rst_n                = 1'b1;
    bus.mmio_req_i       = req;
    bus.mmio_we_i        = we;
    bus.mmio_addr_i      = addr;
    bus.mmio_wdata_i     = wdata;
    bus.mmio_strb_i      = strb;
    bus.mmio_wdata_i_t0  = wdata_t0;
    bus.mmio_req_i_t0    = 1'b0;
    bus.mmio_we_i_t0     = 1'b0;
    bus.mmio_strb_i_t0   = 8'h00;
    bus.mmio_addr_i_t0   = ctl_taint ? 32'h8 : 32'h0;
    cons_ready           = ready;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, BASE32, '0, '0, 8'h00, 0, ready);
  endtask

  task automatic rdReg(input logic [31:0] addr, input bit ready);
    applyStimulus(1, 0, addr, '0, '0, 8'hFF, 0, ready);
  endtask

  task automatic wrReg(input logic [31:0] addr, input logic [63:0] d, input logic [63:0] t,
                       input bit ready);
    applyStimulus(1, 1, addr, d, t, 8'hFF, 0, ready);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n               = 1'b0;
    bus.mmio_req_i      = 1'b0;
    bus.mmio_we_i       = 1'b0;
    bus.mmio_addr_i     = '0;
    bus.mmio_wdata_i    = '0;
    bus.mmio_strb_i     = '0;
    bus.mmio_wdata_i_t0 = '0;
    bus.mmio_req_i_t0   = 1'b0;
    bus.mmio_we_i_t0    = 1'b0;
    bus.mmio_strb_i_t0  = '0;
    bus.mmio_addr_i_t0  = '0;
    cons_ready          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
  endtask

  task automatic checkOutput(input string tag);
    logic [15:0] head;
    cmp({tag, ":stop"}, stop, 64'(m_state == 2));
    cmp({tag, ":stop_code"}, stop_code, m_stop);
    cmp({tag, ":stop_code_t0"}, stop_code_t0, m_stop_t0);
    cmp({tag, ":alarm"}, taint_alarm, 64'(m_alarm));
    cmp({tag, ":cons_valid"}, cons_valid, 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      head = m_fifo[0];
      cmp({tag, ":cons_data"}, cons_data, head[7:0]);
      cmp({tag, ":cons_data_t0"}, cons_data_t0, head[15:8]);
    end
  endtask

  // Read-response monitor: a read sampled on one edge must be answered just after it.
  always @(posedge clk) begin
    if (rst_n && bus.mmio_req_i === 1'b1 && bus.mmio_we_i === 1'b0) begin
      #1;
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL rd_response: got %h, want no response", bus.mmio_rdata_o);
      end else begin
        rd_head = exp_rd.pop_front();
        cmp("rd_data", bus.mmio_rdata_o, rd_head.data);
        cmp("rd_taint", bus.mmio_rdata_o_t0, rd_head.taint);
      end
    end
  end

  // Console monitor: every byte the sink takes must be the oldest accepted push.
  always @(posedge clk) begin
    if (rst_n && cons_valid === 1'b1 && cons_ready === 1'b1) begin
      if (exp_cons.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL cons_pop: got %h, want no byte", cons_data);
      end else begin
        cons_head = exp_cons.pop_front();
        cmp("cons_pop_data", cons_data, cons_head[7:0]);
        cmp("cons_pop_taint", cons_data_t0, cons_head[15:8]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addrs [8];
    logic [31:0] a;
    logic [63:0] d, t;
    int          k;
    bit          rdy;
    addrs[0] = BASE32 + 32'd8;  addrs[1] = BASE32 + 32'd12; addrs[2] = BASE32 + 32'd16;
    addrs[3] = BASE32 + 32'd24; addrs[4] = BASE32 + 32'd31; addrs[5] = BASE32 - 32'd8;
    addrs[6] = BASE32 + 32'd32; addrs[7] = BASE32 + 32'd20;

    $display("[TB] reset and cycle counter");
    doReset();
    cmp("reset_rdata", bus.mmio_rdata_o, 64'd0);
    cmp("reset_rdata_t0", bus.mmio_rdata_o_t0, 64'd0);
    cmp("reset_cons_data", cons_data, 64'd0);
    checkOutput("reset");
    idle(10, 0);
    rdReg(BASE32 + 32'd16, 0);
    cmp("cycle_after_10", bus.mmio_rdata_o, 64'd10);
    cmp("cycle_taint", bus.mmio_rdata_o_t0, 64'd0);

    $display("[TB] console push and overflow");
    wrReg(BASE32 + 32'd8, 64'h41, 64'h80, 0);
    cmp("putc_valid", cons_valid, 64'd1);
    cmp("putc_data", cons_data, 64'h41);
    cmp("putc_taint", cons_data_t0, 64'h80);
    rdReg(BASE32 + 32'd24, 0);
    cmp("status_count1", bus.mmio_rdata_o[7:0], 64'd1);
    for (int i = 0; i < 8; i++) wrReg(BASE32 + 32'd8, 64'($urandom), 64'($urandom), 0);
    rdReg(BASE32 + 32'd24, 0);
    cmp("status_full_ovf", bus.mmio_rdata_o[8:0], 64'h108);
    checkOutput("full");
    wrReg(BASE32 + 32'd24, 64'h100, '0, 0);
    rdReg(BASE32 + 32'd24, 0);
    cmp("status_ovf_cleared", bus.mmio_rdata_o[8], 64'd0);
    wrReg(BASE32 + 32'd8, 64'h5A, 64'h0F, 1);
    rdReg(BASE32 + 32'd24, 0);
    checkOutput("full_push_pop");

    $display("[TB] randomized traffic");
    doReset();
    for (int i = 0; i < 250; i++) begin
      k   = $urandom_range(0, 9);
      a   = addrs[$urandom_range(0, 7)];
      d   = {$urandom, $urandom};
      t   = {$urandom, $urandom};
      rdy = 1'($urandom_range(0, 1));
      case (k)
        0, 1, 2: applyStimulus(0, 0, a, d, t, 8'h00, 0, rdy);
        3, 4:    applyStimulus(1, 0, a, d, t, 8'hFF, 0, rdy);
        5, 6:    applyStimulus(1, 1, BASE32 + 32'd8, d, t, 8'($urandom), 0, rdy);
        7:       applyStimulus(1, 1, BASE32 + 32'd24, d, t, 8'hFF, 0, rdy);
        8:       applyStimulus(1, 1, a, d, t, 8'($urandom), 0, rdy);
        default: applyStimulus(1, 0, BASE32 + 32'd24, d, t, 8'hFF, 0, rdy);
      endcase
      checkOutput("rand");
    end
    idle(12, 1);
    checkOutput("rand_flushed");

    $display("[TB] stop and drain");
    doReset();
    for (int i = 0; i < 3; i++) wrReg(BASE32 + 32'd8, 64'(8'h30 + i), '0, 0);
    wrReg(BASE32, 64'h1, 64'h0, 0);
    wrReg(BASE32, 64'hFF, 64'hFF, 0);
    idle(6, 0);
    rdReg(BASE32 + 32'd24, 0);
    cmp("drain_held", bus.mmio_rdata_o[11:10], 64'd1);
    checkOutput("drain_held");
    for (int i = 0; i < 12; i++) begin
      idle(1, 1);
      checkOutput("drain_release");
    end
    cmp("stopped", stop, 64'd1);
    cmp("stop_code_one", stop_code, 64'd1);
    rdReg(BASE32 + 32'd16, 0);
    idle(5, 0);
    rdReg(BASE32 + 32'd16, 0);
    rdReg(BASE32, 0);
    rdReg(BASE32 + 32'd24, 0);

    $display("[TB] tainted control");
    doReset();
    applyStimulus(1, 0, BASE32 + 32'd24, '0, '0, 8'hFF, 1, 0);
    cmp("taint_rd_t0", bus.mmio_rdata_o_t0, {64{1'b1}});
    idle(100, 0);
    cmp("alarm_sticky", taint_alarm, 64'd1);
    checkOutput("alarm_sticky");
    rdReg(BASE32 + 32'd24, 0);
    doReset();
    cmp("alarm_reset", taint_alarm, 64'd0);

`ifdef MMIO_TAINT_TRAP_EN
    $display("[TB] taint trap");
    idle(1, 0);
    wrReg(BASE32, 64'h5, 64'h1, 0);
    cmp("trap_code", stop_code, 64'hDEAD_7A1E);
    cmp("trap_code_t0", stop_code_t0, {64{1'b1}});
    checkOutput("trap");
`endif

    idle(3, 0);
    cmp("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
